// File: rtl/mips_datapath_alu_muldiv_if.sv
// Request/result bus between the EX-stage issuer and the multiply/divide unit.
interface mips_datapath_alu_muldiv_if #(
  parameter int unsigned DATA_W = 32
);
  logic              op_valid;
  logic [2:0]        op;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              flush;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output op_valid, op, op_a, op_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op, op_a, op_b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_datapath_alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Multiply is shift-add retiring MUL_STEP multiplier bits per cycle; divide is
// restoring, one quotient bit per cycle. Both work on magnitudes and apply
// signs in a single FIX cycle.
module mips_datapath_alu_muldiv #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input logic                       clk,
  input logic                       rst,
  mips_datapath_alu_muldiv_if.slave bus
);

  localparam int unsigned MUL_CYC = DATA_W / MUL_STEP;
  localparam int unsigned DIV_CYC = DATA_W;
  localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
  localparam int unsigned PW      = 2 * DATA_W;
  localparam int unsigned SW      = DATA_W + MUL_STEP;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  count;
  logic              is_div;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;
  logic [DATA_W-1:0] oper;
  logic [DATA_W-1:0] rem;
  logic [PW-1:0]     prod;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              busy_q;
  logic              done_q;

  logic              accept;
  logic              op_muldiv;
  logic              op_signed;
  logic              op_is_div;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic              last;

  logic [SW-1:0]       partial;
  logic [SW-1:0]       sum;
  logic [PW+MUL_STEP-1:0] mul_cat;
  logic [PW-1:0]       mul_next;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic                div_ge;
  logic [DATA_W-1:0]   rem_next;
  logic [DATA_W-1:0]   quo_next;
  logic [PW-1:0]       prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  // Request decode; magnitude of the most negative value is its own bit pattern read unsigned
  assign accept    = bus.op_valid & ~busy_q & ~bus.flush;
  assign op_muldiv = ~bus.op[2];
  assign op_signed = ~bus.op[0];
  assign op_is_div = bus.op[1];
  assign a_neg     = op_signed & bus.op_a[DATA_W-1];
  assign b_neg     = op_signed & bus.op_b[DATA_W-1];
  assign a_mag     = a_neg ? -bus.op_a : bus.op_a;
  assign b_mag     = b_neg ? -bus.op_b : bus.op_b;
  assign last      = (count == (is_div ? CNT_W'(DIV_CYC - 1) : CNT_W'(MUL_CYC - 1)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; flush wins from any state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && op_muldiv) state_next = CALC;
      CALC:    if (last) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  // One iteration of shift-add multiply / restoring divide, plus sign fix-up
  always_comb begin
    partial   = SW'(oper) * SW'(prod[MUL_STEP-1:0]);
    sum       = SW'(prod[PW-1:DATA_W]) + partial;
    mul_cat   = {sum, prod[DATA_W-1:0]};
    mul_next  = PW'(mul_cat >> MUL_STEP);
    div_shift = {rem, prod[DATA_W-1]};
    div_diff  = div_shift - {1'b0, oper};
    div_ge    = (div_shift >= {1'b0, oper});
    rem_next  = DATA_W'(div_ge ? div_diff : div_shift);
    quo_next  = {prod[DATA_W-2:0], div_ge};
    prod_fix  = neg_q ? -prod : prod;
    quo_fix   = neg_q ? -prod[DATA_W-1:0] : prod[DATA_W-1:0];
    rem_fix   = neg_r ? -rem : rem;
  end

  // Operand latch, iteration registers and HI/LO write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      oper     <= '0;
      rem      <= '0;
      prod     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= (state_next != IDLE);
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.op == OP_MTHI) hi_q <= bus.op_a;
            if (bus.op == OP_MTLO) lo_q <= bus.op_a;
            if (op_muldiv) begin
              count    <= '0;
              is_div   <= op_is_div;
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              div_zero <= op_is_div & (bus.op_b == '0);
              rem      <= '0;
              oper     <= op_is_div ? b_mag : a_mag;
              prod     <= {{DATA_W{1'b0}}, (op_is_div ? a_mag : b_mag)};
            end
          end
        end
        CALC: begin
          count <= count + CNT_W'(1);
          if (is_div) begin
            rem  <= rem_next;
            prod <= {prod[PW-1:DATA_W], quo_next};
          end else begin
            prod <= mul_next;
          end
        end
        FIX: begin
          if (!bus.flush) begin
            done_q <= 1'b1;
            if (is_div) begin
              hi_q <= rem_fix;
              lo_q <= div_zero ? {DATA_W{1'b1}} : quo_fix;
            end else begin
              hi_q <= prod_fix[PW-1:DATA_W];
              lo_q <= prod_fix[DATA_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_datapath_alu_muldiv.sv
// Randomised and directed checks of the mul/div unit against a plain-arithmetic model.
module tb_mips_datapath_alu_muldiv;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MUL_STEP = 4;
  localparam int          MUL_BUSY = DATA_W / MUL_STEP + 1;
  localparam int          DIV_BUSY = DATA_W + 1;

  typedef logic [DATA_W-1:0] word_t;
  localparam word_t MIN_W = {1'b1, {(DATA_W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst;

  mips_datapath_alu_muldiv_if #(.DATA_W(DATA_W)) bus ();

  mips_datapath_alu_muldiv #(
    .DATA_W   (DATA_W),
    .MUL_STEP (MUL_STEP)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    n_vec    = 0;
  int    n_miscmp = 0;
  word_t exp_hi   = '0;
  word_t exp_lo   = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result {hi, lo} straight from integer arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input word_t a, input word_t b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    model = 64'h0;
    case (op)
      3'd0: model = 64'(sa * sb);
      3'd1: model = ua * ub;
      3'd2, 3'd3: begin
        if (b == '0) model = {a, {DATA_W{1'b1}}};
        else if (op == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          model = {word_t'(r), word_t'(q)};
        end else begin
          model = {word_t'(ua % ub), word_t'(ua / ub)};
        end
      end
      default: model = 64'h0;
    endcase
  endfunction

  function automatic word_t pick();
    case ($urandom_range(0, 6))
      0:       pick = '0;
      1:       pick = word_t'(1);
      2:       pick = '1;
      3:       pick = MIN_W;
      4:       pick = ~MIN_W;
      5:       pick = word_t'($urandom_range(0, 20));
      default: pick = word_t'($urandom());
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from idle and check timing, done pulse and HI/LO
  task automatic do_op(input logic [2:0] op, input word_t a, input word_t b);
    logic [63:0] r;
    int          n;
    bit          held;
    string       tag;
    tag = $sformatf("op%0d a=%h b=%h", op, a, b);
    r = model(op, a, b);
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.op_a     = a;
    bus.op_b     = b;
    tick();
    bus.op_valid = 1'b0;
    if (op[2]) begin
      if (op == 3'd4) exp_hi = a;
      if (op == 3'd5) exp_lo = a;
      check({tag, " busy"}, 64'(bus.busy), 64'(0));
      check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
      check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    end else begin
      n = 0;
      held = 1'b1;
      while (bus.busy === 1'b1 && n < 100) begin
        if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.done !== 1'b0) held = 1'b0;
        n++;
        tick();
      end
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      check({tag, " busy_cycles"}, 64'(n), 64'(op[1] ? DIV_BUSY : MUL_BUSY));
      check({tag, " hold_while_busy"}, 64'(held), 64'(1));
      check({tag, " done"}, 64'(bus.done), 64'(1));
      check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
      check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
      tick();
      check({tag, " done_drop"}, 64'(bus.done), 64'(0));
    end
  endtask

  // Start DIV, flush after wait_n cycles of busy; nothing architectural may change
  task automatic flush_test(input int wait_n);
    bit saw_done;
    bus.op_valid = 1'b1;
    bus.op       = 3'd2;
    bus.op_a     = word_t'(1000);
    bus.op_b     = word_t'(7);
    tick();
    bus.op_valid = 1'b0;
    repeat (wait_n) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check($sformatf("flush@%0d busy", wait_n), 64'(bus.busy), 64'(0));
    check($sformatf("flush@%0d done", wait_n), 64'(bus.done), 64'(0));
    check($sformatf("flush@%0d hi", wait_n), 64'(bus.hi), 64'(exp_hi));
    check($sformatf("flush@%0d lo", wait_n), 64'(bus.lo), 64'(exp_lo));
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    check($sformatf("flush@%0d quiet", wait_n), 64'(saw_done), 64'(0));
  endtask

  initial begin
    logic [63:0] r;
    int          n;
    bit          held;
    logic [2:0]  rop;

    rst          = 1'b1;
    bus.op_valid = 1'b0;
    bus.op       = '0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset done", 64'(bus.done), 64'(0));
    check("reset hi", 64'(bus.hi), 64'(0));
    check("reset lo", 64'(bus.lo), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed corner cases
    do_op(3'd0, word_t'(-3), word_t'(7));
    do_op(3'd1, '1, '1);
    do_op(3'd2, word_t'(-7), word_t'(2));
    do_op(3'd2, MIN_W, '1);
    do_op(3'd3, word_t'(32'h1234), '0);
    do_op(3'd2, word_t'(-5), '0);
    do_op(3'd2, word_t'(7), word_t'(-2));
    do_op(3'd0, MIN_W, MIN_W);
    do_op(3'd4, word_t'(5), '0);
    do_op(3'd5, word_t'(9), '0);
    do_op(3'd6, word_t'(77), word_t'(1));
    do_op(3'd7, word_t'(78), word_t'(1));

    // Request held during busy is taken on the first idle cycle
    r = model(3'd2, word_t'(100), word_t'(9));
    bus.op_valid = 1'b1;
    bus.op       = 3'd2;
    bus.op_a     = word_t'(100);
    bus.op_b     = word_t'(9);
    tick();
    bus.op   = 3'd4;
    bus.op_a = word_t'(32'hCAFEF00D);
    n = 0;
    held = 1'b1;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.hi !== exp_hi) held = 1'b0;
      n++;
      tick();
    end
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    check("held_req busy_cycles", 64'(n), 64'(DIV_BUSY));
    check("held_req hi_stable", 64'(held), 64'(1));
    check("held_req div hi", 64'(bus.hi), 64'(exp_hi));
    tick();
    bus.op_valid = 1'b0;
    exp_hi = word_t'(32'hCAFEF00D);
    check("held_req mthi hi", 64'(bus.hi), 64'(exp_hi));
    check("held_req lo", 64'(bus.lo), 64'(exp_lo));
    check("held_req busy", 64'(bus.busy), 64'(0));

    // Flush in IDLE drops the op
    bus.op_valid = 1'b1;
    bus.op       = 3'd5;
    bus.op_a     = word_t'(32'hDEAD0001);
    bus.flush    = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    check("idle_flush lo", 64'(bus.lo), 64'(exp_lo));
    check("idle_flush busy", 64'(bus.busy), 64'(0));

    flush_test(10);
    flush_test(DIV_BUSY - 1);

    // Randomised ops against the model
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      do_op(rop, pick(), pick());
    end

    // Asynchronous reset mid-divide
    bus.op_valid = 1'b1;
    bus.op       = 3'd2;
    bus.op_a     = word_t'(12345);
    bus.op_b     = word_t'(11);
    tick();
    bus.op_valid = 1'b0;
    repeat (10) tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst busy", 64'(bus.busy), 64'(0));
    check("async_rst done", 64'(bus.done), 64'(0));
    check("async_rst hi", 64'(bus.hi), 64'(0));
    check("async_rst lo", 64'(bus.lo), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    tick();
    do_op(3'd1, word_t'(6), word_t'(7));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
